// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: S-box tables, round count, decipher FSM
// state type and 64-bit permutation/substitution layer helpers.
// The encryption datapath imports the same package.
package present_pkg;

  localparam logic [4:0] ROUNDS = 5'd31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ROUNDS
  } dec_state_t;

  // Destination of bit i in the forward bit permutation.
  function automatic int p_pos(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[p_pos(i)] = x[i];
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[i] = x[p_pos(i)];
    return y;
  endfunction

  function automatic logic [63:0] s_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = SBOX[x[4*n +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] inv_s_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = INV_SBOX[x[4*n +: 4]];
    return y;
  endfunction

endpackage

// File: rtl/present80_key_step.sv
// One PRESENT-80 key-schedule step, combinational.
// Ports:
//   dir     : 0 = forward K(rc) -> K(rc+1), 1 = inverse K(rc+1) -> K(rc)
//   rc      : 5-bit round counter mixed into key bits [19:15]
//   key_in  : 80-bit key register value
//   key_out : stepped key
module present80_key_step
  import present_pkg::*;
(
  input  logic        dir,
  input  logic [4:0]  rc,
  input  logic [79:0] key_in,
  output logic [79:0] key_out
);

  logic [79:0] fwd_key;
  logic [79:0] inv_mix;

  always_comb begin
    // forward: rotate left 61, substitute top nibble, mix counter
    fwd_key          = {key_in[18:0], key_in[79:19]};
    fwd_key[79:76]   = SBOX[fwd_key[79:76]];
    fwd_key[19:15]   = fwd_key[19:15] ^ rc;
    // inverse: undo the same three operations in reverse order
    inv_mix          = key_in;
    inv_mix[19:15]   = inv_mix[19:15] ^ rc;
    inv_mix[79:76]   = INV_SBOX[inv_mix[79:76]];
    key_out          = dir ? {inv_mix[60:0], inv_mix[79:61]} : fwd_key;
  end

endmodule

// File: rtl/present80_decipher.sv
// Iterative PRESENT-80 decryption core. Expands the user key forward to
// K32 (one step per clock), whitens the ciphertext with K32, then runs the
// 31 inverse rounds one per clock while walking the key schedule back.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : decrypt request, honoured only in idle
//   key        : 80-bit user key, captured with start
//   ciphertext : 64-bit block, captured with start
//   busy       : operation in progress
//   done       : one-cycle pulse, plaintext valid
//   plaintext  : result, held until the next done
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_KEYEXP | forward key expansion, rc 1..31, whitening on the last step
// ST_ROUNDS | inverse rounds, rc 31..1, result captured when rc = 1
module present80_decipher
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] ciphertext,
  output logic        busy,
  output logic        done,
  output logic [63:0] plaintext
);

  dec_state_t  fsm;
  logic [79:0] key_reg;
  logic [63:0] state_reg;
  logic [4:0]  rc;
  logic [63:0] pt_reg;

  logic [79:0] ks_out;
  logic [63:0] round_out;

  // In ST_ROUNDS key_reg holds K(rc+1); the inverse step yields K(rc).
  present80_key_step u_key_step (
    .dir     (fsm == ST_ROUNDS),
    .rc      (rc),
    .key_in  (key_reg),
    .key_out (ks_out)
  );

  assign round_out = inv_s_layer64(inv_p_layer(state_reg)) ^ ks_out[79:16];
  assign plaintext = pt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      key_reg   <= '0;
      state_reg <= '0;
      rc        <= '0;
      pt_reg    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            key_reg   <= key;
            state_reg <= ciphertext;
            rc        <= 5'd1;
            busy      <= 1'b1;
            fsm       <= ST_KEYEXP;
          end
        end
        ST_KEYEXP: begin
          key_reg <= ks_out;
          if (rc == ROUNDS) begin
            // rc stays at 31: the first inverse round undoes step 31
            state_reg <= state_reg ^ ks_out[79:16];
            fsm       <= ST_ROUNDS;
          end else begin
            rc <= rc + 5'd1;
          end
        end
        ST_ROUNDS: begin
          state_reg <= round_out;
          key_reg   <= ks_out;
          rc        <= rc - 5'd1;
          if (rc == 5'd1) begin
            pt_reg <= round_out;
            done   <= 1'b1;
            busy   <= 1'b0;
            fsm    <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
